seq_pattern_tx: RTL

//   Transmit end of the serial "101" sequence link: takes a parallel word plus bit

---
 rtl/seq_pattern_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// Serial "101" link transmitter: loads a frame over valid/ready, shifts it out MSB-first
// one bit per clock, and counts overlapping "101" patterns actually driven on the line.
module seq_pattern_tx #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 6,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             clr_hits,
  output logic             tx_seq,
  output logic             tx_valid,
  output logic             done,
  output logic [HIT_W-1:0] hit_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [LEN_W-1:0] bits_left, bits_nxt;
  logic             tx_seq_nxt, tx_valid_nxt, done_nxt;
  logic [LEN_W-1:0] len_eff;
  logic [WIDTH-1:0] aligned;
  logic             accept;
  logic [1:0]       hist;
  logic             hit;

  // Left-justify the frame so its first bit sits in the MSB of the shifter.
  always_comb begin
    len_eff = load_len;
    if (load_len == '0 || load_len > WIDTH_L) len_eff = WIDTH_L;
    aligned = load_data << (WIDTH_L - len_eff);
  end

  always_comb begin
    load_ready = (state == IDLE) || (state == SHIFT && bits_left == LEN_W'(1));
    accept     = load_valid && load_ready;
  end

  // bits_left counts the bits still on the line, including the one showing now.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    bits_nxt     = bits_left;
    tx_seq_nxt   = 1'b0;
    tx_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    if (accept) begin
      state_nxt    = SHIFT;
      tx_seq_nxt   = aligned[WIDTH-1];
      shift_nxt    = aligned << 1;
      bits_nxt     = len_eff;
      tx_valid_nxt = 1'b1;
      done_nxt     = (len_eff == LEN_W'(1));
    end else begin
      case (state)
        SHIFT: begin
          if (bits_left == LEN_W'(1)) begin
            state_nxt = IDLE;
            bits_nxt  = '0;
            shift_nxt = '0;
          end else begin
            tx_seq_nxt   = shift_reg[WIDTH-1];
            shift_nxt    = shift_reg << 1;
            bits_nxt     = bits_left - LEN_W'(1);
            tx_valid_nxt = 1'b1;
            done_nxt     = (bits_left == LEN_W'(2));
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bits_left <= '0;
      tx_seq    <= 1'b0;
      tx_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bits_left <= bits_nxt;
      tx_seq    <= tx_seq_nxt;
      tx_valid  <= tx_valid_nxt;
      done      <= done_nxt;
    end
  end

  // History shifts every cycle so idle gaps break patterns like a line-side detector.
  always_comb hit = ({hist, tx_seq} == 3'b101);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      <= 2'b00;
      hit_count <= '0;
    end else begin
      hist <= {hist[0], tx_seq};
      if (clr_hits)
        hit_count <= '0;
      else if (hit && hit_count != '1)
        hit_count <= hit_count + HIT_W'(1);
    end
  end

endmodule
